// File: rtl/clock_pkg.sv
// Shared constants for the 1 Hz strobe chain and time-of-day display path.
package clock_pkg;

  localparam int unsigned SEC_MOD    = 60;
  localparam int unsigned MIN_MOD    = 60;
  localparam int unsigned HOUR_MOD   = 24;
  localparam int unsigned TICK_COUNT = 125_000_000;  // CLK cycles per 1 Hz strobe
  localparam logic [7:0]  BCD_ZERO   = 8'h00;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_t;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD with synchronous clear and combinational wrap flag.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLR,
  input  logic       INC,
  output logic [7:0] Q,
  output logic       WRAP
);

  localparam logic [7:0] LAST = to_bcd(MOD - 1);

  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] next;

  assign tens  = Q[7:4];
  assign units = Q[3:0];
  assign WRAP  = INC && (Q == LAST);

  // Any illegal digit, or running past 99, falls back to 00 on the next increment.
  always_comb begin
    next = Q;
    if (CLR) begin
      next = BCD_ZERO;
    end else if (INC) begin
      if (tens > 4'd9 || units > 4'd9 || Q == LAST || Q == 8'h99)
        next = BCD_ZERO;
      else if (units == 4'd9)
        next = {tens + 4'd1, 4'd0};
      else
        next = {tens, units + 4'd1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) Q <= BCD_ZERO;
    else       Q <= next;
  end

endmodule

// File: rtl/time_bcd_counter.sv
// BCD hh:mm:ss time-of-day counter driven by a 1 Hz strobe, with button time-set mode.
module time_bcd_counter
  import clock_pkg::*;
#(
  parameter int unsigned SEC_MOD  = clock_pkg::SEC_MOD,
  parameter int unsigned MIN_MOD  = clock_pkg::MIN_MOD,
  parameter int unsigned HOUR_MOD = clock_pkg::HOUR_MOD
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       SET_MODE,
  input  logic       INC_MIN,
  input  logic       INC_HOUR,
  output logic [7:0] SEC_BCD,
  output logic [7:0] MIN_BCD,
  output logic [7:0] HOUR_BCD,
  output logic       MIN_TICK,
  output logic       HOUR_TICK,
  output logic       DAY_TICK
);

  mode_t mode;
  logic  run;
  logic  sec_inc, min_inc, hour_inc;
  logic  sec_wrap, min_wrap, hour_wrap;

  assign mode = SET_MODE ? MODE_SET : MODE_RUN;
  assign run  = (mode == MODE_RUN);

  // Run mode chains carries; set mode feeds each field straight from its button.
  assign sec_inc  = run && ENABLE;
  assign min_inc  = run ? sec_wrap : INC_MIN;
  assign hour_inc = run ? min_wrap : INC_HOUR;

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .CLK(CLK), .RESET(RESET), .CLR(!run), .INC(sec_inc),
    .Q(SEC_BCD), .WRAP(sec_wrap)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .CLK(CLK), .RESET(RESET), .CLR(1'b0), .INC(min_inc),
    .Q(MIN_BCD), .WRAP(min_wrap)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .CLK(CLK), .RESET(RESET), .CLR(1'b0), .INC(hour_inc),
    .Q(HOUR_BCD), .WRAP(hour_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MIN_TICK  <= 1'b0;
      HOUR_TICK <= 1'b0;
      DAY_TICK  <= 1'b0;
    end else begin
      MIN_TICK  <= run && sec_wrap;
      HOUR_TICK <= run && min_wrap;
      DAY_TICK  <= run && hour_wrap;
    end
  end

endmodule
